// File: rtl/odd_result_pipe.sv
// Result-staging pipeline for the odd execution pipe: DEPTH registered stages, stall,
// partial flush, per-stage ready tracking and a writeback register. Optional lookup: ODD_RESULT_PIPE_FWD_LOOKUP_EN.
module odd_result_pipe #(
    parameter int DATA_W       = 128,
    parameter int REG_W        = 7,
    parameter int UNIT_W       = 3,
    parameter int LAT_W        = 4,
    parameter int DEPTH        = 7,
    parameter int FLUSH_STAGES = 2,
    localparam int ENTRY_W     = UNIT_W + DATA_W + REG_W + LAT_W + 1,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [UNIT_W-1:0]        in_unit_id,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [REG_W-1:0]         in_reg_dst,
    input  logic [LAT_W-1:0]         in_latency,
    input  logic                     in_reg_wr,
    output logic [DEPTH*ENTRY_W-1:0] stage_bus,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH-1:0]         stage_ready,
    output logic [OCC_W-1:0]         occupancy,
`ifdef ODD_RESULT_PIPE_FWD_LOOKUP_EN
    input  logic [REG_W-1:0]         fwd_addr,
    output logic                     fwd_hit,
    output logic                     fwd_pending,
    output logic [DATA_W-1:0]        fwd_data,
`endif
    output logic                     wb_en,
    output logic [REG_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]        wb_data
);

    localparam int LAT_LO  = 1;
    localparam int DST_LO  = LAT_LO + LAT_W;
    localparam int DATA_LO = DST_LO + REG_W;

    // Index 0 is stage 1 (youngest), index DEPTH-1 is stage DEPTH (oldest).
    logic [ENTRY_W-1:0] stage_q [DEPTH];
    logic [ENTRY_W-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [OCC_W-1:0]   occ_d;
    logic [ENTRY_W-1:0] in_entry;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        in_entry = {in_unit_id, in_data, in_reg_dst, in_latency, in_reg_wr};
        valid_d  = valid_q;
        for (int k = 0; k < DEPTH; k++) stage_d[k] = stage_q[k];

        if (flush) begin
            // The youngest FLUSH_STAGES slots empty; everything older still advances.
            stage_d[0] = '0;
            valid_d[0] = 1'b0;
            for (int k = 1; k < DEPTH; k++) begin
                if (k < FLUSH_STAGES) begin
                    stage_d[k] = '0;
                    valid_d[k] = 1'b0;
                end else begin
                    stage_d[k] = stage_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end
        end else if (!stall) begin
            stage_d[0] = in_valid ? in_entry : '0;
            valid_d[0] = in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end

        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) occ_d = occ_d + OCC_W'(valid_d[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stage registers are reset too, because stage_bus must read as zero after reset.
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            valid_q   <= '0;
            occupancy <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
            valid_q   <= valid_d;
            occupancy <= occ_d;
            if (flush || !stall) begin
                wb_en   <= valid_q[DEPTH-1] & stage_q[DEPTH-1][0];
                wb_addr <= stage_q[DEPTH-1][DST_LO +: REG_W];
                wb_data <= stage_q[DEPTH-1][DATA_LO +: DATA_W];
            end else begin
                // The held stage DEPTH entry writes once, when the stall releases.
                wb_en <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_bus
        assign stage_bus[(DEPTH-1-g)*ENTRY_W +: ENTRY_W] = stage_q[g];
    end

    assign stage_valid = valid_q;

    // Effective latency is max(latency,1), clamped to DEPTH so long-latency results still become ready.
    always_comb begin
        int lat_i;
        lat_i       = 0;
        stage_ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lat_i = int'(stage_q[k][LAT_LO +: LAT_W]);
            if (lat_i < 1)     lat_i = 1;
            if (lat_i > DEPTH) lat_i = DEPTH;
            stage_ready[k] = valid_q[k] && ((k + 1) >= lat_i);
        end
    end

`ifdef ODD_RESULT_PIPE_FWD_LOOKUP_EN
    // Youngest matching writer decides; the writeback register is the oldest candidate and always ready.
    always_comb begin
        logic found;
        found       = 1'b0;
        fwd_hit     = 1'b0;
        fwd_pending = 1'b0;
        fwd_data    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && valid_q[k] && stage_q[k][0] &&
                stage_q[k][DST_LO +: REG_W] == fwd_addr) begin
                found = 1'b1;
                if (stage_ready[k]) begin
                    fwd_hit  = 1'b1;
                    fwd_data = stage_q[k][DATA_LO +: DATA_W];
                end else begin
                    fwd_pending = 1'b1;
                end
            end
        end
        if (!found && wb_en && wb_addr == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data;
        end
    end
`endif

endmodule
